buzzer_sched: RTL and testbench



---
 rtl/buzzer_sched.sv | 274 +++++++++++++++++++++++++++
 tb/tb_buzzer_sched.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sched.sv
// ---------------------------------------------------------------------------
// buzzer_sched
//
// Decides what the buzzer plays and when: key-click beeps, hourly chimes
// (one strike per hour on a 12-hour dial) and a looping alarm melody. The
// result is a half-period word for a downstream tone generator, where 0
// means silence.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   on          master enable; low forces silence and drops all activity
//   tick        one-cycle timebase pulse (10 Hz nominal) that paces phases
//   alarm_req   level request; the alarm plays while it is high
//   chime_req   one-cycle pulse asking for an hourly chime
//   hour        hour 0-23, sampled together with chime_req
//   beep_req    one-cycle pulse asking for a key beep
//   period      registered half-period word, 0 = silent
//   busy        registered, high whenever something is playing
//   src         registered source code: 00 none, 01 beep, 10 chime, 11 alarm
//   chime_done  registered one-cycle pulse when a chime finishes all strikes
// ---------------------------------------------------------------------------
module buzzer_sched #(
   parameter int NOTE_TICKS  = 5,
   parameter int STRIKE_ON   = 5,
   parameter int STRIKE_OFF  = 5,
   parameter int BEEP_TICKS  = 2,
   parameter int BEEP_PERIOD = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        on,
   input  logic        tick,
   input  logic        alarm_req,
   input  logic        chime_req,
   input  logic [5:0]  hour,
   input  logic        beep_req,
   output logic [19:0] period,
   output logic        busy,
   output logic [1:0]  src,
   output logic        chime_done
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_BEEP      = 3'd1;
   localparam logic [2:0] ST_CHIME_ON  = 3'd2;
   localparam logic [2:0] ST_CHIME_OFF = 3'd3;
   localparam logic [2:0] ST_ALARM     = 3'd4;

   localparam logic [19:0] TONE_PERIOD  = 20'(BEEP_PERIOD);
   localparam logic [15:0] NOTE_LAST    = 16'(NOTE_TICKS - 1);
   localparam logic [15:0] STRIKE_ON_LAST  = 16'(STRIKE_ON - 1);
   localparam logic [15:0] STRIKE_OFF_LAST = 16'(STRIKE_OFF - 1);
   localparam logic [15:0] BEEP_LAST    = 16'(BEEP_TICKS - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  note_idx_q, note_idx_d;
   logic        pending_q, pending_d;
   logic [3:0]  strikes_q, strikes_d;
   logic [19:0] period_q, period_d;
   logic        busy_q, busy_d;
   logic [1:0]  src_q, src_d;
   logic        chime_done_q, chime_done_d;

   logic        chime_ok;
   logic [3:0]  hour_mod;
   logic [3:0]  hour_strikes;

   // Alarm melody, one half-period word per note; zeros are rests.
   function automatic logic [19:0] note_period(input logic [3:0] idx);
      logic [19:0] p;
      case (idx)
         4'd0:    p = 20'd113636;
         4'd1:    p = 20'd170300;
         4'd2:    p = 20'd151700;
         4'd3:    p = 20'd191131;
         4'd4:    p = 20'd191131;
         4'd5:    p = 20'd0;
         4'd6:    p = 20'd191131;
         4'd7:    p = 20'd143184;
         4'd8:    p = 20'd113636;
         4'd9:    p = 20'd170300;
         4'd10:   p = 20'd0;
         4'd11:   p = 20'd191131;
         4'd12:   p = 20'd191131;
         4'd13:   p = 20'd0;
         4'd14:   p = 20'd191131;
         default: p = 20'd0;
      endcase
      return p;
   endfunction

   // A chime request is only usable with a real hour, when nothing is
   // already queued and no chime is currently sounding. The strike count
   // folds the hour onto a 12-hour dial where midnight and noon strike 12.
   always_comb begin
      chime_ok = chime_req && (hour <= 6'd23) && !pending_q &&
                 (state_q != ST_CHIME_ON) && (state_q != ST_CHIME_OFF);
      hour_mod = (hour >= 6'd12) ? 4'(hour - 6'd12) : hour[3:0];
      hour_strikes = (hour_mod == 4'd0) ? 4'd12 : hour_mod;
   end

   // Next-state logic. The alarm overrides everything whenever it is
   // requested, so it is handled ahead of the per-state behaviour. Every
   // phase timer only moves on tick cycles and restarts on phase entry.
   // A chime that arrives while IDLE starts straight away instead of going
   // through the pending flag, so it wins over a same-cycle beep.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      note_idx_d   = note_idx_q;
      pending_d    = pending_q;
      strikes_d    = strikes_q;
      chime_done_d = 1'b0;

      if (!on) begin
         state_d    = ST_IDLE;
         timer_d    = 16'd0;
         note_idx_d = 4'd0;
         pending_d  = 1'b0;
         strikes_d  = 4'd0;
      end else if (alarm_req) begin
         if (state_q != ST_ALARM) begin
            state_d    = ST_ALARM;
            timer_d    = 16'd0;
            note_idx_d = 4'd0;
         end else if (tick) begin
            if (timer_q == NOTE_LAST) begin
               timer_d    = 16'd0;
               note_idx_d = note_idx_q + 4'd1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         if (chime_ok) begin
            pending_d = 1'b1;
            strikes_d = hour_strikes;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pending_q || chime_ok) begin
                  state_d   = ST_CHIME_ON;
                  timer_d   = 16'd0;
                  pending_d = 1'b0;
                  if (chime_ok) begin
                     strikes_d = hour_strikes;
                  end
               end else if (beep_req) begin
                  state_d = ST_BEEP;
                  timer_d = 16'd0;
               end
            end
            ST_BEEP: begin
               if (chime_ok) begin
                  pending_d = 1'b1;
                  strikes_d = hour_strikes;
               end
               if (tick) begin
                  if (timer_q == BEEP_LAST) begin
                     state_d = ST_IDLE;
                     timer_d = 16'd0;
                  end else begin
                     timer_d = timer_q + 16'd1;
                  end
               end
            end
            ST_CHIME_ON: begin
               if (tick) begin
                  if (timer_q == STRIKE_ON_LAST) begin
                     state_d = ST_CHIME_OFF;
                     timer_d = 16'd0;
                  end else begin
                     timer_d = timer_q + 16'd1;
                  end
               end
            end
            ST_CHIME_OFF: begin
               if (tick) begin
                  if (timer_q == STRIKE_OFF_LAST) begin
                     timer_d = 16'd0;
                     if (strikes_q <= 4'd1) begin
                        state_d      = ST_IDLE;
                        strikes_d    = 4'd0;
                        chime_done_d = 1'b1;
                     end else begin
                        state_d   = ST_CHIME_ON;
                        strikes_d = strikes_q - 4'd1;
                     end
                  end else begin
                     timer_d = timer_q + 16'd1;
                  end
               end
            end
            ST_ALARM: begin
               // alarm_req has dropped: fall back to IDLE first, a queued
               // chime gets picked up from there on the following cycle
               state_d    = ST_IDLE;
               timer_d    = 16'd0;
               note_idx_d = 4'd0;
               if (chime_ok) begin
                  pending_d = 1'b1;
                  strikes_d = hour_strikes;
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = 16'd0;
            end
         endcase
      end
   end

   // Outputs are decoded from the upcoming state so that, once registered,
   // they line up with the state they describe.
   always_comb begin
      period_d = 20'd0;
      busy_d   = (state_d != ST_IDLE);
      src_d    = 2'b00;
      case (state_d)
         ST_BEEP: begin
            period_d = TONE_PERIOD;
            src_d    = 2'b01;
         end
         ST_CHIME_ON: begin
            period_d = TONE_PERIOD;
            src_d    = 2'b10;
         end
         ST_CHIME_OFF: begin
            src_d = 2'b10;
         end
         ST_ALARM: begin
            period_d = note_period(note_idx_d);
            src_d    = 2'b11;
         end
         default: begin
            period_d = 20'd0;
            src_d    = 2'b00;
         end
      endcase
   end

   // State and output registers; reset silences everything mid-phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= 16'd0;
         note_idx_q   <= 4'd0;
         pending_q    <= 1'b0;
         strikes_q    <= 4'd0;
         period_q     <= 20'd0;
         busy_q       <= 1'b0;
         src_q        <= 2'b00;
         chime_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         note_idx_q   <= note_idx_d;
         pending_q    <= pending_d;
         strikes_q    <= strikes_d;
         period_q     <= period_d;
         busy_q       <= busy_d;
         src_q        <= src_d;
         chime_done_q <= chime_done_d;
      end
   end

   assign period     = period_q;
   assign busy       = busy_q;
   assign src        = src_q;
   assign chime_done = chime_done_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// ---------------------------------------------------------------------------
// tb_buzzer_sched
//
// Self-checking bench for buzzer_sched: a hand-computed vector table, a few
// directed multi-cycle sequences and a long random run, all compared against
// a behavioural model that tracks "what is playing and for how many ticks".
// ---------------------------------------------------------------------------
module tb_buzzer_sched;

   localparam int NOTE_TICKS  = 5;
   localparam int STRIKE_ON   = 5;
   localparam int STRIKE_OFF  = 5;
   localparam int BEEP_TICKS  = 2;
   localparam int BEEP_PERIOD = 20000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        on = 1'b0;
   logic        tick = 1'b0;
   logic        alarm_req = 1'b0;
   logic        chime_req = 1'b0;
   logic [5:0]  hour = 6'd0;
   logic        beep_req = 1'b0;
   logic [19:0] period;
   logic        busy;
   logic [1:0]  src;
   logic        chime_done;

   int checks = 0;
   int failures = 0;

   int noteTable[16] = '{113636, 170300, 151700, 191131, 191131, 0, 191131, 143184,
                         113636, 170300, 0, 191131, 191131, 0, 191131, 0};

   // Model: mode is the source code (0 none, 1 beep, 2 chime, 3 alarm) and
   // elapsed counts ticks since the activity began.
   int mMode = 0;
   int mElapsed = 0;
   int mStrikes = 0;
   int mPendStrikes = 0;
   bit mPending = 1'b0;
   bit mDone = 1'b0;

   bit prevOn = 1'b0;
   int dones = 0;
   int strikes = 0;

   typedef struct {
      bit rst; bit on; bit tick; bit alarm; bit chime; int hour; bit beep;
      int period; bit busy; int src; bit done;
   } vec_t;

   vec_t vecs[25];

   always #5 clk = ~clk;

   buzzer_sched #(
      .NOTE_TICKS(NOTE_TICKS), .STRIKE_ON(STRIKE_ON), .STRIKE_OFF(STRIKE_OFF),
      .BEEP_TICKS(BEEP_TICKS), .BEEP_PERIOD(BEEP_PERIOD)
   ) dut (
      .clk(clk), .rst(rst), .on(on), .tick(tick), .alarm_req(alarm_req),
      .chime_req(chime_req), .hour(hour), .beep_req(beep_req),
      .period(period), .busy(busy), .src(src), .chime_done(chime_done)
   );

   function automatic int strikesFor(input int h);
      int m;
      m = h % 12;
      return (m == 0) ? 12 : m;
   endfunction

   function automatic int expPeriod();
      int p;
      case (mMode)
         1: p = BEEP_PERIOD;
         2: p = ((mElapsed % (STRIKE_ON + STRIKE_OFF)) < STRIKE_ON) ? BEEP_PERIOD : 0;
         3: p = noteTable[(mElapsed / NOTE_TICKS) % 16];
         default: p = 0;
      endcase
      return p;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      bit cv;
      mDone = 1'b0;
      if (rst || !on) begin
         mMode = 0;
         mElapsed = 0;
         mPending = 1'b0;
         return;
      end
      cv = chime_req && (hour <= 6'd23) && !mPending && (mMode != 2);
      if (alarm_req) begin
         if (mMode != 3) begin
            mMode = 3;
            mElapsed = 0;
         end else if (tick) begin
            mElapsed++;
         end
         if (cv) begin
            mPending = 1'b1;
            mPendStrikes = strikesFor(int'(hour));
         end
      end else begin
         case (mMode)
            0: begin
               if (mPending || cv) begin
                  mStrikes = cv ? strikesFor(int'(hour)) : mPendStrikes;
                  mPending = 1'b0;
                  mMode = 2;
                  mElapsed = 0;
               end else if (beep_req) begin
                  mMode = 1;
                  mElapsed = 0;
               end
            end
            1: begin
               if (cv) begin
                  mPending = 1'b1;
                  mPendStrikes = strikesFor(int'(hour));
               end
               if (tick) begin
                  mElapsed++;
                  if (mElapsed == BEEP_TICKS) mMode = 0;
               end
            end
            2: begin
               if (tick) begin
                  mElapsed++;
                  if (mElapsed == mStrikes * (STRIKE_ON + STRIKE_OFF)) begin
                     mMode = 0;
                     mDone = 1'b1;
                  end
               end
            end
            default: begin
               mMode = 0;
               if (cv) begin
                  mPending = 1'b1;
                  mPendStrikes = strikesFor(int'(hour));
               end
            end
         endcase
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then settle 1 time unit.
   task automatic applyStimulus(input bit r, input bit o, input bit t, input bit a,
                                input bit c, input int h, input bit b);
      rst = r;
      on = o;
      tick = t;
      alarm_req = a;
      chime_req = c;
      hour = 6'(h);
      beep_req = b;
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic checkOutput(input string name);
      int ep;
      ep = expPeriod();
      checks++;
      if (int'(period) !== ep || busy !== (mMode != 0) || int'(src) !== mMode ||
          chime_done !== mDone) begin
         failures++;
         $display("[TB] FAIL %s @%0t: got period=%0d busy=%0b src=%0d done=%0b, want period=%0d busy=%0b src=%0d done=%0b",
                  name, $time, period, busy, src, chime_done, ep, (mMode != 0), mMode, mDone);
      end
   endtask

   task automatic checkVal(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
      end
   endtask

   // Count strike onsets and chime_done pulses as seen on the outputs.
   task automatic observe();
      bit onNow;
      onNow = (int'(period) == BEEP_PERIOD) && (src == 2'd2);
      if (onNow && !prevOn) strikes++;
      prevOn = onNow;
      if (chime_done === 1'b1) dones++;
   endtask

   task automatic step(input bit r, input bit o, input bit t, input bit a,
                       input bit c, input int h, input bit b, input string name);
      applyStimulus(r, o, t, a, c, h, b);
      checkOutput(name);
      observe();
   endtask

   task automatic clearCounts();
      dones = 0;
      strikes = 0;
      prevOn = 1'b0;
   endtask

   initial begin
      int hrs[3];
      int want[3];
      bit aLvl;

      // rst on tk al ch hr bp   period busy src done
      vecs[0]  = '{1, 0, 0, 0, 0,  0, 0,      0, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 0,  0, 0,      0, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 0, 0,  0, 1,  20000, 1, 1, 0};
      vecs[3]  = '{0, 1, 1, 0, 0,  0, 0,  20000, 1, 1, 0};
      vecs[4]  = '{0, 1, 0, 0, 0,  0, 0,  20000, 1, 1, 0};
      vecs[5]  = '{0, 1, 1, 0, 0,  0, 0,      0, 0, 0, 0};
      vecs[6]  = '{0, 1, 0, 0, 1, 30, 0,      0, 0, 0, 0};
      vecs[7]  = '{0, 1, 0, 0, 1, 13, 1,  20000, 1, 2, 0};
      vecs[8]  = '{0, 1, 1, 0, 0,  0, 0,  20000, 1, 2, 0};
      vecs[9]  = '{0, 1, 1, 0, 0,  0, 0,  20000, 1, 2, 0};
      vecs[10] = '{0, 1, 1, 0, 0,  0, 0,  20000, 1, 2, 0};
      vecs[11] = '{0, 1, 1, 0, 0,  0, 0,  20000, 1, 2, 0};
      vecs[12] = '{0, 1, 1, 0, 0,  0, 0,      0, 1, 2, 0};
      vecs[13] = '{0, 1, 0, 0, 0,  0, 1,      0, 1, 2, 0};
      vecs[14] = '{0, 1, 1, 0, 0,  0, 0,      0, 1, 2, 0};
      vecs[15] = '{0, 1, 1, 0, 0,  0, 0,      0, 1, 2, 0};
      vecs[16] = '{0, 1, 1, 0, 0,  0, 0,      0, 1, 2, 0};
      vecs[17] = '{0, 1, 1, 0, 0,  0, 0,      0, 1, 2, 0};
      vecs[18] = '{0, 1, 1, 0, 0,  0, 0,      0, 0, 0, 1};
      vecs[19] = '{0, 1, 0, 0, 0,  0, 0,      0, 0, 0, 0};
      vecs[20] = '{0, 1, 0, 1, 0,  0, 0, 113636, 1, 3, 0};
      vecs[21] = '{0, 0, 0, 1, 0,  0, 0,      0, 0, 0, 0};
      vecs[22] = '{0, 1, 0, 1, 0,  0, 0, 113636, 1, 3, 0};
      vecs[23] = '{1, 1, 0, 1, 0,  0, 0,      0, 0, 0, 0};
      vecs[24] = '{0, 1, 0, 0, 0,  0, 0,      0, 0, 0, 0};

      // Hand-computed table: reset, beep, ignored hour, chime vs beep,
      // beep during CHIME_OFF, alarm entry, on=0 and rst over an alarm.
      for (int i = 0; i < 25; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].on, vecs[i].tick, vecs[i].alarm,
                       vecs[i].chime, vecs[i].hour, vecs[i].beep);
         checks++;
         if (int'(period) !== vecs[i].period || busy !== vecs[i].busy ||
             int'(src) !== vecs[i].src || chime_done !== vecs[i].done) begin
            failures++;
            $display("[TB] FAIL vec%0d: got period=%0d busy=%0b src=%0d done=%0b, want period=%0d busy=%0b src=%0d done=%0b",
                     i, period, busy, src, chime_done, vecs[i].period, vecs[i].busy,
                     vecs[i].src, vecs[i].done);
         end
      end

      // Chime strike counts for an afternoon hour, midnight and noon.
      hrs = '{15, 0, 12};
      want = '{3, 12, 12};
      for (int k = 0; k < 3; k++) begin
         clearCounts();
         step(0, 1, 0, 0, 1, hrs[k], 0, "chime start");
         for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 0, 0, 0, "chime run");
         checkVal("chime strikes", strikes, want[k]);
         checkVal("chime done pulses", dones, 1);
         checkVal("chime idle src", int'(src), 0);
      end

      // Out-of-range hour is ignored.
      clearCounts();
      step(0, 1, 0, 0, 1, 30, 0, "bad hour");
      for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 0, "bad hour run");
      checkVal("bad hour strikes", strikes, 0);
      checkVal("bad hour busy", int'(busy), 0);

      // Alarm melody over 90 ticks, including the wrap back to note 0.
      step(0, 1, 0, 1, 0, 0, 0, "alarm entry");
      checkVal("alarm note0", int'(period), 113636);
      for (int k = 1; k <= 90; k++) begin
         step(0, 1, 1, 1, 0, 0, 0, "alarm run");
         if (k == 5) checkVal("alarm note1", int'(period), 170300);
         if (k == 79) checkVal("alarm note15", int'(period), 0);
         if (k == 80) checkVal("alarm wrap", int'(period), 113636);
      end
      step(0, 1, 0, 0, 0, 0, 0, "alarm release");
      checkVal("alarm release period", int'(period), 0);
      checkVal("alarm release src", int'(src), 0);

      // Alarm preempts strike 2 of a chime; a chime requested during the
      // alarm plays in full afterwards.
      clearCounts();
      step(0, 1, 0, 0, 1, 3, 0, "preempt chime start");
      for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0, 0, "preempt chime run");
      step(0, 1, 0, 1, 0, 0, 0, "preempt alarm");
      checkVal("preempt src", int'(src), 3);
      step(0, 1, 1, 1, 1, 2, 0, "chime in alarm");
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, 0, 0, "alarm hold");
      for (int i = 0; i < 100; i++) step(0, 1, 1, 0, 0, 0, 0, "post alarm");
      checkVal("preempt done count", dones, 1);
      checkVal("preempt total strikes", strikes, 4);

      // rst mid-alarm drops a pending chime.
      step(0, 1, 0, 1, 0, 0, 0, "rst alarm");
      step(0, 1, 1, 1, 1, 5, 0, "rst alarm chime");
      step(1, 1, 1, 1, 0, 0, 0, "rst hit");
      checkVal("rst period", int'(period), 0);
      checkVal("rst src", int'(src), 0);
      checkVal("rst busy", int'(busy), 0);
      clearCounts();
      for (int i = 0; i < 80; i++) step(0, 1, 1, 0, 0, 0, 0, "after rst");
      checkVal("no chime after rst", strikes, 0);

      // on=0 mid-alarm likewise.
      step(0, 1, 0, 1, 0, 0, 0, "off alarm");
      step(0, 1, 1, 1, 1, 7, 0, "off alarm chime");
      step(0, 0, 1, 1, 0, 0, 0, "off hit");
      checkVal("off period", int'(period), 0);
      checkVal("off src", int'(src), 0);
      checkVal("off busy", int'(busy), 0);
      clearCounts();
      for (int i = 0; i < 80; i++) step(0, 1, 1, 0, 0, 0, 0, "after off");
      checkVal("no chime after off", strikes, 0);

      // Random traffic against the model.
      aLvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) aLvl = !aLvl;
         step($urandom_range(0, 299) == 0, $urandom_range(0, 99) != 0,
              $urandom_range(0, 1) == 1, aLvl, $urandom_range(0, 39) == 0,
              int'($urandom_range(0, 31)), $urandom_range(0, 9) == 0, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
